config_reg_bank: RTL
====================

// Module: config_reg_bank
// PURPOSE
//  Bank of NUM_REGS config registers written byte-serially over the 32-bit PS GPIO bus
//  (addr[15:0], data[23:16], w_clk[24]). Bytes shift into shadow registers, MSB first.
//  A write to COMMIT_ADDR transfers all shadows to reg_out in one cycle, so multi-byte,
//  multi-register settings change atomically. Sits between the PS GPIO and RFSoC datapath control.
// PARAMETERS
//  REG_BYTES  4      bytes per register; register width W = 8*REG_BYTES
//  NUM_REGS   4      registers; reg i is at bus address BASE_ADDR+i
//  BASE_ADDR  16'h0  bus address of reg 0
//  COMMIT_ADDR 16'hFFFF  control address; must not lie in [BASE_ADDR, BASE_ADDR+NUM_REGS-1]
//  RESET_VAL  all 1s  W-bit reset value of every shadow and reg_out word
// PORTS
//  clk           in   1              system clock
//  rst           in   1              asynchronous reset, active-high
//  gpio_in       in   32             GPIO bus, asynchronous to clk
//  reg_out       out  NUM_REGS*W     committed registers; reg i at [i*W +: W]
//  commit_pulse  out  1              one-cycle pulse when a commit is applied
//  pending       out  1              shadows written since last commit/abort
//  overrun       out  1              sticky: a register got >REG_BYTES bytes since last commit/abort
// BEHAVIOUR
//  Reset (rst=1, async): shadows and reg_out = RESET_VAL; per-reg byte counters = 0;
//   commit_pulse = pending = overrun = 0; sync stages and w_prev = 0. Effect is immediate,
//   even mid-sequence; partially written bytes are lost.
//  Input sync: all 32 bits of gpio_in go through 2 flop stages (bus_s). w_prev = bus_s[24] delayed 1.
//   Write event = bus_s[24] & ~w_prev. Addr/data come from bus_s in the same cycle.
//   Software holds addr/data stable while w_clk is high.
//  Latency: w_clk rising before clk edge k -> event decoded after edge k+1 -> state update at edge k+2.
//  Exactly one event per w_clk rising edge. w_clk held high gives no repeat. Low time >=2 clk.
//  Data write (addr = BASE_ADDR+i): shadow[i] <= {shadow[i][W-9:0], data}. REG_BYTES=1 -> replace.
//   cnt[i] counts bytes and saturates at REG_BYTES. A byte arriving while cnt[i]==REG_BYTES sets overrun.
//   Excess bytes still shift: oldest byte discarded. pending <= 1.
//  Control write (addr = COMMIT_ADDR), data bit0 = COMMIT, bit1 = ABORT:
//   COMMIT: reg_out <= all shadows in the same edge; commit_pulse = 1 for the next cycle.
//     Clears cnt, pending, overrun. A commit with pending=0 still pulses.
//   ABORT (bit0=0): shadows <= reg_out; clears cnt, pending, overrun; no pulse.
//   Both bits set: COMMIT wins. Neither set: no effect.
//  Any other address: ignored, no state change.
//  reg_out changes only on COMMIT or reset. Data bytes never reach reg_out directly.
//  Implementation: flat shadow/active arrays; address compare against BASE_ADDR with unsigned
//   subtract and range check (no wrap: BASE_ADDR+NUM_REGS-1 <= 16'hFFFF).
// TESTING
//  1 Reset: rst pulse mid-clock -> reg_out all 1s immediately, pending/overrun/commit_pulse 0.
//  2 Bytes 12,34,56,78 to BASE_ADDR+1, then COMMIT (data 01) -> reg 1 = 32'h12345678,
//    others all 1s. commit_pulse high exactly 1 cycle. reg_out unchanged before commit.
//  3 Write reg 0 = AABBCCDD and reg 3 = 01020304 -> reg_out unchanged, pending=1.
//    COMMIT -> both update on the same edge, pending=0.
//  4 Five bytes 11..55 to reg 2 -> overrun=1. COMMIT -> reg 2 = 22334455, overrun cleared.
//  5 Write reg 0 = 0, then ABORT (data 02) -> shadow reloads to RESET_VAL, pending=0.
//    Bare COMMIT -> reg 0 still all 1s, commit_pulse fires.
//  6 w_clk held high 20 cycles, write to unmapped addr 16'h0100, data 03 to COMMIT_ADDR ->
//    one event only, unmapped addr ignored, 03 acts as COMMIT.
//    Check 2-cycle sync latency to the state update.

Source files
------------

// File: rtl/config_reg_bank.sv
`default_nettype none
// ============================================================================
//  Module      : config_reg_bank
//  Description : Byte-serial shadow/commit configuration register bank fed
//                from a 32-bit PS GPIO bus (addr[15:0], data[23:16], w_clk[24]).
//  Revision    : 1.0 - initial release
// ============================================================================
module config_reg_bank #(
    parameter int                     REG_BYTES   = 4,
    parameter int                     NUM_REGS    = 4,
    parameter logic [15:0]            BASE_ADDR   = 16'h0000,
    parameter logic [15:0]            COMMIT_ADDR = 16'hFFFF,
    parameter logic [8*REG_BYTES-1:0] RESET_VAL   = '1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [31:0]                       gpio_in,
    output logic [NUM_REGS*8*REG_BYTES-1:0]   reg_out,
    output logic                              commit_pulse,
    output logic                              pending,
    output logic                              overrun
);

    localparam int              c_width   = 8 * REG_BYTES;
    localparam int              c_cnt_w   = $clog2(REG_BYTES + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(REG_BYTES);
    localparam logic [16:0]     c_num_regs = 17'(NUM_REGS);

    logic [31:0]          r_sync1;
    logic [31:0]          r_bus_s;
    logic                 r_w_prev;
    logic                 r_commit_pulse;
    logic                 r_pending;
    logic                 r_overrun;

    logic [c_width-1:0]   r_shadow  [NUM_REGS];
    logic [c_width-1:0]   r_active  [NUM_REGS];
    logic [c_cnt_w-1:0]   r_cnt     [NUM_REGS];
    logic [c_width-1:0]   w_shifted [NUM_REGS];

    logic                 w_event;
    logic [15:0]          w_addr;
    logic [7:0]           w_data;
    logic [15:0]          w_offset;
    logic                 w_in_range;
    logic                 w_ctrl;
    logic                 w_commit;
    logic                 w_abort;
    logic [NUM_REGS-1:0]  w_hit;
    logic [NUM_REGS-1:0]  w_sat;
    logic                 w_unused_bits;

    // Two-stage synchronizer on the whole bus; software holds addr/data stable
    // while w_clk is high, so sampling them alongside the strobe is safe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1  <= '0;
            r_bus_s  <= '0;
            r_w_prev <= 1'b0;
        end else begin
            r_sync1  <= gpio_in;
            r_bus_s  <= r_sync1;
            r_w_prev <= r_bus_s[24];
        end
    end

    assign w_event       = r_bus_s[24] & ~r_w_prev;
    assign w_addr        = r_bus_s[15:0];
    assign w_data        = r_bus_s[23:16];
    assign w_unused_bits = ^r_bus_s[31:25];

    // Unsigned offset plus lower-bound check; the mapped window never wraps.
    assign w_offset   = w_addr - BASE_ADDR;
    assign w_in_range = (w_addr >= BASE_ADDR) && ({1'b0, w_offset} < c_num_regs);

    assign w_ctrl   = w_event && (w_addr == COMMIT_ADDR);
    assign w_commit = w_ctrl & w_data[0];
    assign w_abort  = w_ctrl & ~w_data[0] & w_data[1];

    genvar i;
    generate
        for (i = 0; i < NUM_REGS; i++) begin : g_reg
            assign w_hit[i] = w_event && w_in_range && (w_offset == 16'(i));
            assign w_sat[i] = (r_cnt[i] == c_cnt_max);

            if (c_width > 8) begin : g_shift
                assign w_shifted[i] = {r_shadow[i][c_width-9:0], w_data};
            end else begin : g_replace
                assign w_shifted[i] = w_data;
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_shadow[i] <= RESET_VAL;
                    r_active[i] <= RESET_VAL;
                    r_cnt[i]    <= '0;
                end else if (w_commit) begin
                    r_active[i] <= r_shadow[i];
                    r_cnt[i]    <= '0;
                end else if (w_abort) begin
                    r_shadow[i] <= r_active[i];
                    r_cnt[i]    <= '0;
                end else if (w_hit[i]) begin
                    r_shadow[i] <= w_shifted[i];
                    if (!w_sat[i]) begin
                        r_cnt[i] <= r_cnt[i] + c_cnt_w'(1);
                    end
                end
            end

            assign reg_out[i*c_width +: c_width] = r_active[i];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_commit_pulse <= 1'b0;
            r_pending      <= 1'b0;
            r_overrun      <= 1'b0;
        end else begin
            r_commit_pulse <= w_commit;
            if (w_commit || w_abort) begin
                r_pending <= 1'b0;
                r_overrun <= 1'b0;
            end else if (|w_hit) begin
                r_pending <= 1'b1;
                if (|(w_hit & w_sat)) begin
                    r_overrun <= 1'b1;
                end
            end
        end
    end

    assign commit_pulse = r_commit_pulse;
    assign pending      = r_pending;
    assign overrun      = r_overrun;

endmodule
`default_nettype wire
